// File: rtl/sw_debounce.sv
// Per-bit switch debouncer: two-flop synchronizer, an independent stability counter per bit, and a
// registered change pulse. Optional sticky irq/irq_clear when SW_DEBOUNCE_IRQ_EN is defined.
module sw_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             sw_changed
`ifdef SW_DEBOUNCE_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clear
`endif
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] clean_bits;
  logic [WIDTH-1:0] update;
  logic             sw_changed_q;
  logic             sw_changed_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      state_t          state_q;
      logic [CW-1:0]   cnt_q;
      logic            clean_q;
      logic            differ;

      assign differ         = sync2_q[gi] ^ clean_q;
      assign update[gi]     = (state_q == ST_PENDING) && differ && (cnt_q == CNT_MAX);
      assign clean_bits[gi] = clean_q;

      // Counter only runs while PENDING and is cleared on every exit, so it never wraps.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
          clean_q <= 1'b0;
        end else begin
          case (state_q)
            ST_STABLE: begin
              if (differ) begin
                state_q <= ST_PENDING;
                cnt_q   <= CNT_ONE;
              end
            end
            ST_PENDING: begin
              if (!differ) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
              end else if (cnt_q == CNT_MAX) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                clean_q <= sync2_q[gi];
              end else begin
                cnt_q   <= cnt_q + CNT_ONE;
              end
            end
            default: begin
              state_q <= ST_STABLE;
              cnt_q   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  assign sw_changed_d = |update;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_changed_q <= 1'b0;
    end else begin
      sw_changed_q <= sw_changed_d;
    end
  end

  assign sw_clean   = clean_bits;
  assign sw_changed = sw_changed_q;

`ifdef SW_DEBOUNCE_IRQ_EN
  logic irq_q;

  // A new change outranks a clear arriving on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else if (sw_changed_d) begin
      irq_q <= 1'b1;
    end else if (irq_clear) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 10, number of switch bits.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), consecutive stable cycles required; legal range >= 2.
REQ-003 Port clk, input, 1, single system clock; all logic on rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port sw_raw, input, WIDTH, raw asynchronous board switch levels.
REQ-006 Port sw_clean, output, WIDTH, registered debounced switch levels; drives the switch bus of the downstream switch reader.
REQ-007 Port sw_changed, output, 1, registered one-cycle pulse, any sw_clean bit updated.
REQ-008 Port irq, output, 1, sticky change flag; present only with SW_DEBOUNCE_IRQ_EN.
REQ-009 Port irq_clear, input, 1, synchronous clear of irq; present only with SW_DEBOUNCE_IRQ_EN.

Function
REQ-010 Each sw_raw bit SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Each bit SHALL own an independent stability counter, width ceil(log2(DEBOUNCE_CYCLES)).
REQ-012 Per-bit state machine SHALL have two states: STABLE (synced == clean, counter held at 0) and PENDING (synced != clean, counter incrementing).
REQ-013 STABLE -> PENDING on the first cycle synced differs from clean; counter loads 1 on that edge.
REQ-014 PENDING -> STABLE without update when synced returns equal to clean; counter clears to 0 on that edge.
REQ-015 PENDING: when counter equals DEBOUNCE_CYCLES-1 and synced still differs, clean bit SHALL take synced value, counter SHALL clear, state returns to STABLE, all on the same edge.
REQ-016 Latency: a raw level held steady SHALL appear on sw_clean exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-017 Any glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL leave sw_clean unchanged.
REQ-018 Counter SHALL never wrap; maximum value DEBOUNCE_CYCLES-1.
REQ-019 sw_changed SHALL assert on the same edge as any sw_clean bit update and deassert the next cycle unless another bit updates.
REQ-020 Simultaneous updates of multiple bits SHALL produce one sw_changed pulse for that cycle.
REQ-021 Bits SHALL be fully independent; activity on one bit never resets another bit's counter.

Reset
REQ-022 reset_n low SHALL immediately clear synchronizer flops, sw_clean, all counters, sw_changed and irq to 0, regardless of clk.
REQ-023 Reset mid-PENDING SHALL discard the partial count; no update occurs.
REQ-024 After reset release, switches physically high SHALL debounce normally to 1 and generate one sw_changed pulse (and set irq if compiled in).

Configuration
REQ-025 Macro SW_DEBOUNCE_IRQ_EN defined: irq and irq_clear ports exist; irq sets on the edge sw_changed asserts, holds until irq_clear sampled high; set wins over simultaneous clear.
REQ-026 Macro SW_DEBOUNCE_IRQ_EN undefined: irq and irq_clear ports and logic are absent; all other behaviour identical.

Verification (bench uses WIDTH=10, DEBOUNCE_CYCLES=4)
REQ-027 Reset, sw_raw=10'h000 held -> sw_clean=10'h000, sw_changed never asserts.
REQ-028 sw_raw 10'h000 -> 10'h001 held -> sw_clean=10'h001 exactly 6 edges later, sw_changed high for exactly that one cycle.
REQ-029 sw_raw bit 3 high for 2 cycles then low -> sw_clean stays 10'h000, no sw_changed.
REQ-030 Bits 0 and 9 rise on same cycle -> sw_clean=10'h201 after 6 edges, single sw_changed pulse.
REQ-031 reset_n asserted 3 edges into a pending change of bit 5 -> outputs 0 asynchronously; after release, held bit 5 reaches sw_clean 6 edges later.
REQ-032 With SW_DEBOUNCE_IRQ_EN: change -> irq=1 and held; irq_clear pulse -> irq=0 next edge; irq_clear coinciding with sw_changed -> irq stays 1.
